// File: rtl/gpio_input_debounce_if.sv
// Pad-side signal bundle for gpio_input_debounce.
// The master modport is the debounce block, which drives the conditioned levels,
// the edge pulses and the sticky flags. The slave modport is the pad/firmware
// side, which drives the raw pads and the sticky clears.
interface gpio_input_debounce_if #(
  parameter int unsigned N_IN = 4
);
  logic [N_IN-1:0] pad_in;
  logic [N_IN-1:0] gpio_input;
  logic [N_IN-1:0] rise_pulse;
  logic [N_IN-1:0] fall_pulse;
  logic [N_IN-1:0] sticky;
  logic [N_IN-1:0] sticky_clr;

  modport master (
    input  pad_in,
    input  sticky_clr,
    output gpio_input,
    output rise_pulse,
    output fall_pulse,
    output sticky
  );

  modport slave (
    output pad_in,
    output sticky_clr,
    input  gpio_input,
    input  rise_pulse,
    input  fall_pulse,
    input  sticky
  );
endinterface

// File: rtl/gpio_input_debounce.sv
// Per-channel synchroniser, debouncer and edge detector for the board's switch
// and button pads.
// Optional feature macro: GPIO_DEBOUNCE_STICKY_EN. When it is defined, each
// channel keeps a sticky event flag. When it is undefined, sticky is tied to 0
// and sticky_clr is ignored.
module gpio_input_debounce #(
  parameter int unsigned N_IN            = 4,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input logic                   clk,
  input logic                   rst,
  gpio_input_debounce_if.master io
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } ch_state_t;

  logic [N_IN-1:0]  s1;
  logic [N_IN-1:0]  s2;
  logic [N_IN-1:0]  lvl;
  logic [N_IN-1:0]  rise;
  logic [N_IN-1:0]  fall;
  logic [CNT_W-1:0] cnt [N_IN];
  ch_state_t        state [N_IN];

  // Channel state is not stored: a channel is CHANGING whenever the synchronised
  // pad differs from the accepted level.
  always_comb begin
    for (int unsigned i = 0; i < N_IN; i++) begin
      state[i] = (s2[i] == lvl[i]) ? STABLE : CHANGING;
    end
  end

  // Two-flop synchroniser, then a stability counter that accepts a new level
  // only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      lvl  <= '0;
      rise <= '0;
      fall <= '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1   <= io.pad_in;
      s2   <= s1;
      rise <= '0;
      fall <= '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
        case (state[i])
          STABLE: cnt[i] <= '0;
          CHANGING: begin
            if (cnt[i] == CNT_LAST) begin
              lvl[i]  <= s2[i];
              cnt[i]  <= '0;
              rise[i] <= s2[i];
              fall[i] <= ~s2[i];
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          default: cnt[i] <= '0;
        endcase
      end
    end
  end

  assign io.gpio_input = lvl;
  assign io.rise_pulse = rise;
  assign io.fall_pulse = fall;

`ifdef GPIO_DEBOUNCE_STICKY_EN
  logic [N_IN-1:0] sticky_q;

  // Sticky event flags: an edge pulse sets the flag, a clear drops it, and a
  // set wins when both happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (sticky_q & ~io.sticky_clr) | rise | fall;
    end
  end

  assign io.sticky = sticky_q;
`else
  logic [N_IN-1:0] unused_sticky_clr;

  assign unused_sticky_clr = io.sticky_clr;
  assign io.sticky         = '0;
`endif

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Scoreboard bench for gpio_input_debounce with N_IN=4 and DEBOUNCE_CYCLES=4.
// The stimulus process queues each expected edge event. The monitor process
// matches every observed pulse against that queue and tracks the expected level.
module tb_gpio_input_debounce;
  localparam int N = 4;
  localparam int D = 4;
`ifdef GPIO_DEBOUNCE_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif
  localparam logic [N-1:0] SMASK = {N{STK}};

  typedef struct {
    int ch;
    int cyc;
    bit rise;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ev_t  q[$];
  int   cyc = 0;
  bit   rst_seen = 1'b1;
  bit   done = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [N-1:0] exp_lvl = '0;

  always #5 clk = ~clk;

  gpio_input_debounce_if #(.N_IN(N)) io ();

  gpio_input_debounce #(
    .N_IN(N),
    .CNT_W(20),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(io)
  );

  // Cycle counter and record of whether reset was applied at the latest edge.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b want %b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // The pad is sampled at the next edge; level and pulse follow 2+D edges later.
  task automatic expect_ev(input int ch, input bit r);
    ev_t e;
    e.ch   = ch;
    e.cyc  = cyc + 2 + D;
    e.rise = r;
    q.push_back(e);
  endtask

  // Monitor: match observed pulses to queued events and check level tracking.
  always @(negedge clk) begin
    if (cyc > 0 && !done) begin
      if (rst_seen) exp_lvl = '0;
      for (int i = 0; i < N; i++) begin
        if (io.rise_pulse[i] || io.fall_pulse[i]) begin : match
          int idx;
          idx = -1;
          for (int k = 0; k < q.size(); k++) begin
            if (q[k].ch == i) begin
              idx = k;
              break;
            end
          end
          checks++;
          if (idx < 0) begin
            failures++;
            $display("FAIL unexpected_pulse ch%0d cyc=%0d rise=%b fall=%b",
                     i, cyc, io.rise_pulse[i], io.fall_pulse[i]);
          end else begin
            if (q[idx].cyc != cyc || q[idx].rise != io.rise_pulse[i] ||
                io.rise_pulse[i] == io.fall_pulse[i]) begin
              failures++;
              $display("FAIL pulse ch%0d: got cyc=%0d rise=%b fall=%b want cyc=%0d rise=%b fall=%b",
                       i, cyc, io.rise_pulse[i], io.fall_pulse[i],
                       q[idx].cyc, q[idx].rise, ~q[idx].rise);
            end
            exp_lvl[i] = q[idx].rise;
            q.delete(idx);
          end
        end
      end
      check("gpio_level", io.gpio_input, exp_lvl);
`ifndef GPIO_DEBOUNCE_STICKY_EN
      check("sticky_tied_off", io.sticky, '0);
`endif
    end
  end

  // Directed stimulus.
  initial begin
    io.pad_in     = '0;
    io.sticky_clr = '0;
    rst           = 1'b1;
    tick(3);
    check("reset_gpio", io.gpio_input, '0);
    check("reset_rise", io.rise_pulse, '0);
    check("reset_fall", io.fall_pulse, '0);
    check("reset_sticky", io.sticky, '0);
    rst = 1'b0;
    tick(2);

    // Channel 0: a clean press.
    io.pad_in[0] = 1'b1;
    expect_ev(0, 1'b1);
    tick(5);
    check("ch0_not_early", io.gpio_input, 4'b0000);
    tick(5);
    check("sticky_after_press", io.sticky, 4'b0001 & SMASK);

    // Channel 1: a 3-cycle glitch is rejected.
    io.pad_in[1] = 1'b1;
    tick(3);
    io.pad_in[1] = 1'b0;
    tick(10);
    check("ch1_glitch_level", io.gpio_input, 4'b0001);
    check("ch1_glitch_sticky", io.sticky, 4'b0001 & SMASK);

    // Channel 2: bounce 1,0,1,1,0, then hold 1.
    io.pad_in[2] = 1'b1; tick(1);
    io.pad_in[2] = 1'b0; tick(1);
    io.pad_in[2] = 1'b1; tick(2);
    io.pad_in[2] = 1'b0; tick(1);
    io.pad_in[2] = 1'b1;
    expect_ev(2, 1'b1);
    tick(12);
    check("ch2_bounce_level", io.gpio_input, 4'b0101);
    check("ch2_bounce_sticky", io.sticky, 4'b0101 & SMASK);

    // Channel 0 release: the flag stays set.
    io.pad_in[0] = 1'b0;
    expect_ev(0, 1'b0);
    tick(10);
    check("ch0_release_level", io.gpio_input, 4'b0100);
    check("sticky_hold_release", io.sticky, 4'b0101 & SMASK);

    // A one-cycle clear.
    io.sticky_clr[0] = 1'b1;
    tick(1);
    io.sticky_clr[0] = 1'b0;
    check("sticky_clear", io.sticky, 4'b0100 & SMASK);

    // A clear in the same cycle as a set: the set wins.
    io.pad_in[0] = 1'b1;
    expect_ev(0, 1'b1);
    tick(6);
    check("rise_pulse_cycle", io.rise_pulse, 4'b0001);
    check("sticky_before_set", io.sticky, 4'b0100 & SMASK);
    io.sticky_clr[0] = 1'b1;
    tick(1);
    io.sticky_clr[0] = 1'b0;
    check("sticky_set_wins", io.sticky, 4'b0101 & SMASK);

    // Release channels 0 and 2 together: one fall pulse each.
    io.pad_in[0] = 1'b0;
    io.pad_in[2] = 1'b0;
    expect_ev(0, 1'b0);
    expect_ev(2, 1'b0);
    tick(10);
    check("both_released", io.gpio_input, 4'b0000);

    // Channel 3: reset asserted mid-count aborts the change.
    io.pad_in[3] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    check("midreset_gpio", io.gpio_input, '0);
    check("midreset_rise", io.rise_pulse, '0);
    check("midreset_fall", io.fall_pulse, '0);
    check("midreset_sticky", io.sticky, '0);
    rst = 1'b0;
    expect_ev(3, 1'b1);
    tick(5);
    check("ch3_not_early", io.gpio_input, 4'b0000);
    tick(5);
    check("ch3_after_reset", io.gpio_input, 4'b1000);

    done = 1'b1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      foreach (q[k]) begin
        $display("FAIL missing_pulse ch%0d: got none want cyc=%0d rise=%b", q[k].ch, q[k].cyc, q[k].rise);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpio_input_debounce.md
# gpio_input_debounce

Input conditioning stage between the BASYS3 switch/button pads and the `gpio_input` port of `system`. Each raw pad is synchronised into the `clk` domain, debounced with a per-channel stability counter, and presented as a clean level. The block also emits one-cycle rise/fall pulses. Optionally, it keeps sticky event flags so firmware polling through GPIO cannot miss short presses.

## Interface
- `N_IN`, 4: number of input channels.
- `CNT_W`, 20: debounce counter width. Must satisfy `DEBOUNCE_CYCLES <= 2^CNT_W`.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required before a level change is accepted (10 ms at 100 MHz). Minimum 1.
- `clk` input 1: system clock, the only clock.
- `rst` input 1: reset, synchronous, active-high. Drive from the `sys_rst` reset pulse generator output.
- `pad_in` input N_IN: raw asynchronous pad levels.
- `gpio_input` output N_IN: debounced level. Connect to `system.gpio_input`.
- `rise_pulse` output N_IN: one-cycle pulse when a channel's debounced level goes 0→1.
- `fall_pulse` output N_IN: one-cycle pulse when a channel's debounced level goes 1→0.
- `sticky` output N_IN: latched event flag per channel. Only meaningful with `GPIO_DEBOUNCE_STICKY_EN`.
- `sticky_clr` input N_IN: per-channel clear for `sticky`.

## Operation
- All channels are independent and identical. The per-channel state is:
  - sync flops `s1`, `s2`;
  - stable level `lvl`, which drives `gpio_input`;
  - counter `cnt[CNT_W-1:0]`;
  - pulse registers;
  - sticky register.
- Synchroniser: `s1 <= pad_in`, `s2 <= s1`. No logic is applied to `s1`.
- Two-state behaviour per channel, derived from `s2 == lvl`:
  - STABLE (`s2 == lvl`): `cnt <= 0`.
  - CHANGING (`s2 != lvl`):
    - if `cnt == DEBOUNCE_CYCLES-1`: `lvl <= s2`, `cnt <= 0`, and the matching pulse is set for one cycle;
    - otherwise: `cnt <= cnt + 1`.
- Glitch rejection: any cycle with `s2 == lvl` while CHANGING returns the channel to STABLE with `cnt` cleared. The count restarts from 0 on the next difference.
- The counter never wraps. It is cleared before it can reach `DEBOUNCE_CYCLES`.
- Pulses are registered. `rise_pulse[i]` is high exactly in the first cycle that `gpio_input[i]` reads 1, and low otherwise. `fall_pulse` is symmetric.
- Reset values: `s1`, `s2`, `lvl`, `cnt`, `rise_pulse`, `fall_pulse` and `sticky` are all 0.
- A pad held high through reset therefore yields one `rise_pulse` `DEBOUNCE_CYCLES+2` cycles after `rst` deasserts.
- Reset asserted mid-count: the channel returns to the reset state in the next cycle. No pulse is emitted for the aborted change.

## Timing
- Latency: the pad change is sampled at edge 0, and `s2` reflects it after edge 2. `gpio_input` and the pulse update after edge `2+DEBOUNCE_CYCLES`, provided the pad stays stable.
- With `DEBOUNCE_CYCLES=1`, latency is 3 edges and a single-cycle `s2` glitch is accepted.
- Maximum toggle rate is one accepted change per `DEBOUNCE_CYCLES` cycles per channel.
- There are no handshakes. All outputs come directly from flops, with no combinational path from `pad_in` or `sticky_clr`.

## Configuration
- `GPIO_DEBOUNCE_STICKY_EN` defined:
  - `sticky[i]` sets on the cycle after `rise_pulse[i]` or `fall_pulse[i]` is high.
  - It clears on the cycle after `sticky_clr[i]` is high.
  - If a set and a clear occur in the same cycle, set wins.
  - It holds otherwise.
- `GPIO_DEBOUNCE_STICKY_EN` undefined: no sticky registers are instantiated, `sticky` is tied to 0, and `sticky_clr` is ignored. The port list is unchanged.

## Test plan
Run with `N_IN=4`, `DEBOUNCE_CYCLES=4`.

- Reset with all pads 0, then raise `pad_in[0]` and hold → `gpio_input[0]` is 1 and `rise_pulse[0]` pulses exactly 6 edges after the pad is sampled. Other channels stay 0 with no pulses.
- Raise `pad_in[1]` for 3 cycles, then drop it → `gpio_input[1]` stays 0, and neither `rise_pulse[1]` nor `sticky[1]` ever asserts.
- Bounce `pad_in[2]` 1,0,1,1,0 then hold 1 → exactly one `rise_pulse[2]`, occurring 6 edges after the final 0→1. The later release produces exactly one `fall_pulse[2]`.
- Hold `pad_in[3]=1` and assert `rst` for 1 cycle after 2 counting cycles → outputs are 0 in the next cycle. `gpio_input[3]` rises 6 edges after `rst` deasserts, with a single pulse.
- With `GPIO_DEBOUNCE_STICKY_EN`:
  - a press sets `sticky[0]=1`, and it holds after release (which also sets it);
  - `sticky_clr[0]` pulsed for 1 cycle clears it;
  - `sticky_clr[0]` asserted on the same cycle as a set leaves `sticky[0]=1`.
- Without `GPIO_DEBOUNCE_STICKY_EN`: the same stimulus → `sticky` is 4'b0000 throughout, and `gpio_input` and the pulses are identical to the enabled build.
